// File: rtl/guess_entry_ctrl.sv
// Guess-entry controller: collects a 4-digit BCD guess, grades it against a latched secret.
// Define GUESS_HINT_EN to report low/high on a mismatch; otherwise every mismatch reports 01.
module guess_entry_ctrl #(
    parameter int MAX_TRIES   = 8,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        new_game,
    input  logic [15:0] secret,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [7:0]  tries,
    output logic [1:0]  result,
    output logic        result_valid,
    output logic        win,
    output logic        lose,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        CHECK  = 3'd2,
        RESULT = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_t;

    localparam logic [7:0]  MAX_T     = 8'(MAX_TRIES);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    state_t      st;
    logic [15:0] secret_q;
    logic [31:0] hold_cnt;

    assign state = st;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // BCD digit order matches numeric order, so a plain unsigned compare is enough.
    function automatic logic [1:0] grade(input logic [15:0] guess, input logic [15:0] target);
        if (guess == target)
            return 2'b11;
`ifdef GUESS_HINT_EN
        else if (guess < target)
            return 2'b01;
        else
            return 2'b10;
`else
        else
            return 2'b01;
`endif
    endfunction

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            st           <= IDLE;
            entry        <= '0;
            digit_cnt    <= '0;
            tries        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            hold_cnt     <= '0;
            secret_q     <= '0;
        end else begin
            result_valid <= 1'b0;
            // new_game overrides everything, including a key in the same cycle
            if (new_game) begin
                st        <= ENTRY;
                entry     <= '0;
                digit_cnt <= '0;
                tries     <= '0;
                result    <= '0;
                win       <= 1'b0;
                lose      <= 1'b0;
                hold_cnt  <= '0;
                secret_q  <= secret;
            end else begin
                case (st)
                    IDLE: ;
                    ENTRY: begin
                        if (key_valid) begin
                            if (key_code <= 4'h9) begin
                                if (digit_cnt != 3'd4) begin
                                    entry     <= {entry[11:0], key_code};
                                    digit_cnt <= digit_cnt + 3'd1;
                                end
                            end else if (key_code == KEY_BKSP) begin
                                if (digit_cnt != 3'd0) begin
                                    entry     <= {4'h0, entry[15:4]};
                                    digit_cnt <= digit_cnt - 3'd1;
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                entry     <= '0;
                                digit_cnt <= '0;
                            end else if (key_code == KEY_ENTER && digit_cnt == 3'd4) begin
                                st    <= CHECK;
                                tries <= sat_inc(tries);
                            end
                        end
                    end
                    CHECK: begin
                        result       <= grade(entry, secret_q);
                        result_valid <= 1'b1;
                        hold_cnt     <= '0;
                        if (entry == secret_q) begin
                            st  <= WIN;
                            win <= 1'b1;
                        end else if (tries == MAX_T) begin
                            st   <= LOSE;
                            lose <= 1'b1;
                        end else begin
                            st <= RESULT;
                        end
                    end
                    RESULT: begin
                        // result stays on display until the next CHECK overwrites it
                        if (hold_cnt == HOLD_LAST) begin
                            st        <= ENTRY;
                            entry     <= '0;
                            digit_cnt <= '0;
                            hold_cnt  <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    WIN, LOSE: ;
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl with HOLD_CYCLES=4, MAX_TRIES=3.
module tb_guess_entry_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        new_game;
    logic [15:0] secret;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [7:0]  tries;
    logic [1:0]  result;
    logic        result_valid;
    logic        win;
    logic        lose;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    guess_entry_ctrl #(.MAX_TRIES(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .RST(RST), .new_game(new_game), .secret(secret),
        .key_valid(key_valid), .key_code(key_code), .entry(entry),
        .digit_cnt(digit_cnt), .tries(tries), .result(result),
        .result_valid(result_valid), .win(win), .lose(lose), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic start(input logic [15:0] s);
        new_game = 1'b1;
        secret   = s;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic guess(input logic [15:0] g);
        for (int i = 3; i >= 0; i--) press(g[i*4 +: 4]);
        press(4'hF);
    endtask

    logic [1:0] exp_high;
    logic       saw_pulse;

    initial begin
`ifdef GUESS_HINT_EN
        exp_high = 2'b10;
`else
        exp_high = 2'b01;
`endif
        RST = 1'b1; new_game = 1'b0; secret = '0; key_valid = 1'b0; key_code = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_entry", 32'(entry), 32'd0);
        chk("rst_tries", 32'(tries), 32'd0);
        chk("rst_flags", 32'({result, result_valid, win, lose}), 32'd0);
        RST = 1'b0;
        @(negedge clk);

        // IDLE ignores keys
        press(4'h5);
        chk("idle_key_state", 32'(state), 32'd0);
        chk("idle_key_entry", 32'(entry), 32'd0);

        // Win on first guess
        start(16'h1234);
        chk("ng_state", 32'(state), 32'd1);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("win_entry", 32'(entry), 32'h1234);
        chk("win_cnt", 32'(digit_cnt), 32'd4);
        press(4'hF);
        chk("win_check_state", 32'(state), 32'd2);
        chk("win_tries", 32'(tries), 32'd1);
        chk("win_no_early_pulse", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("win_pulse", 32'(result_valid), 32'd1);
        chk("win_result", 32'(result), 32'd3);
        chk("win_state", 32'(state), 32'd4);
        chk("win_flag", 32'({win, lose}), 32'b10);
        @(negedge clk);
        chk("win_pulse_end", 32'(result_valid), 32'd0);
        press(4'hB);
        chk("win_terminal_entry", 32'(entry), 32'h1234);
        chk("win_terminal_state", 32'(state), 32'd4);

        // Editing keys
        start(16'h9999);
        press(4'h7);
        chk("ed_digit", 32'(entry), 32'h0007);
        press(4'hA);
        chk("ed_bksp", 32'({entry, 13'(digit_cnt)}), 32'd0);
        press(4'hA);
        chk("ed_bksp_empty", 32'(digit_cnt), 32'd0);
        press(4'hB);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("ed_full_entry", 32'(entry), 32'h1234);
        chk("ed_full_cnt", 32'(digit_cnt), 32'd4);
        press(4'hA);
        chk("ed_bksp_entry", 32'(entry), 32'h0123);
        press(4'hC);
        chk("ed_ignored_C", 32'(entry), 32'h0123);
        press(4'hF);
        chk("ed_short_enter_state", 32'(state), 32'd1);
        chk("ed_short_enter_tries", 32'(tries), 32'd0);
        press(4'h8);
        press(4'hB);
        chk("ed_clear", 32'({entry, 13'(digit_cnt)}), 32'd0);

        // Hints, hold, and loss
        start(16'h5000);
        guess(16'h4999);
        @(negedge clk);
        chk("low_pulse", 32'(result_valid), 32'd1);
        chk("low_result", 32'(result), 32'b01);
        chk("low_state", 32'(state), 32'd3);
        repeat (3) @(negedge clk);
        chk("hold_still_result", 32'(state), 32'd3);
        chk("hold_result_kept", 32'({result, result_valid}), 32'b010);
        @(negedge clk);
        chk("hold_done_state", 32'(state), 32'd1);
        chk("hold_done_entry", 32'({entry, 13'(digit_cnt)}), 32'd0);
        guess(16'h6000);
        @(negedge clk);
        chk("high_result", 32'(result), 32'(exp_high));
        chk("high_tries", 32'(tries), 32'd2);
        chk("high_state", 32'(state), 32'd3);
        repeat (4) @(negedge clk);
        chk("high_back_entry", 32'(state), 32'd1);
        guess(16'h1111);
        @(negedge clk);
        chk("lose_state", 32'(state), 32'd5);
        chk("lose_flags", 32'({win, lose}), 32'b01);
        chk("lose_tries", 32'(tries), 32'd3);
        press(4'hB); press(4'h2);
        chk("lose_terminal_entry", 32'(entry), 32'h1111);
        start(16'h0042);
        chk("restart_tries", 32'(tries), 32'd0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_flags", 32'({win, lose, result}), 32'd0);

        // new_game beats a same-cycle key
        press(4'h8);
        key_valid = 1'b1; key_code = 4'h5;
        start(16'h4321);
        key_valid = 1'b0;
        chk("ng_key_entry", 32'(entry), 32'd0);
        chk("ng_key_cnt", 32'(digit_cnt), 32'd0);

        // Reset during RESULT
        guess(16'h1234);
        @(negedge clk);
        chk("rr_in_result", 32'(state), 32'd3);
        #2 RST = 1'b1;
        #1;
        chk("rr_async_state", 32'(state), 32'd0);
        chk("rr_async_out", 32'({entry, tries, result, result_valid, digit_cnt}), 32'd0);
        saw_pulse = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid) saw_pulse = 1'b1;
        end
        RST = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid) saw_pulse = 1'b1;
        end
        chk("rr_no_pulse", 32'(saw_pulse), 32'd0);
        chk("rr_idle_after", 32'(state), 32'd0);
        press(4'h3);
        chk("rr_idle_ignores_key", 32'(entry), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
